// File: rtl/iq_demod_pkg.sv
// Shared types and constants for the IQ demodulation sequencer and the
// datapath (filter length is shared with the filter instantiation).
package iq_demod_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FLUSH  = 2'd1,
        ST_WARMUP = 2'd2,
        ST_RUN    = 2'd3
    } state_t;

    localparam int NTAPS_DEF = 20;

    // Bits needed to hold values 0..max_val (at least one bit).
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/iq_ctrl_sat_cnt.sv
// Saturating up-counter with synchronous clear. Clear and increment in the
// same cycle restart the count at one, so an event coinciding with a clear is kept.
module iq_ctrl_sat_cnt #(
    parameter int W   = 8,
    parameter int MAX = 255
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] cnt_reg;
    logic [W-1:0] base;

    always_comb begin
        base = clr ? '0 : cnt_reg;
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_reg <= '0;
        end else if (inc && (base != MAX_V)) begin
            cnt_reg <= base + 1'b1;
        end else begin
            cnt_reg <= base;
        end
    end

    assign cnt = cnt_reg;

endmodule

// File: rtl/iq_demod_ctrl.sv
// Start-up sequencer for the IQ demodulation chain: LO phase clear, zero-sample
// filter flush, warm-up masking, strobe gating and error monitoring.
module iq_demod_ctrl
    import iq_demod_pkg::*;
#(
    parameter int NTAPS     = NTAPS_DEF,
    parameter int WARMUP    = 20,
    parameter int FLUSH_GAP = 4,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             enable_i,
    input  logic             clr_err_i,
    input  logic             adc_rdy_i,
    input  logic             filt_valid_i_i,
    input  logic             filt_valid_q_i,
    input  logic             cordic_ready_i,
    output logic             sample_en_o,
    output logic             zero_sample_o,
    output logic             nco_clr_o,
    output logic             demod_iq_valid_o,
    output logic [1:0]       state_o,
    output logic             overrun_o,
    output logic             desync_o,
    output logic [CNT_W-1:0] drop_cnt_o
);

    localparam int FL_W  = cnt_width(NTAPS);
    localparam int WU_W  = cnt_width(WARMUP);
    localparam int GAP_W = cnt_width(FLUSH_GAP - 1);

    state_t            state_reg, state_next;
    logic              enable_prev_reg;
    logic [GAP_W-1:0]  gap_reg, gap_next;
    logic [FL_W-1:0]   flush_cnt;
    logic [WU_W-1:0]   warm_cnt;

    logic sample_en_reg, sample_en_next;
    logic zero_sample_reg, zero_sample_next;
    logic nco_clr_reg, nco_clr_next;
    logic demod_valid_reg, demod_valid_next;

    logic gap_term, pair, desync_evt, drop_evt, cnt_clr;
    logic flush_inc, warm_inc;
    logic [1:0] flag_set, flags;

    assign gap_term   = (gap_reg == GAP_W'(FLUSH_GAP - 1));
    assign pair       = filt_valid_i_i & filt_valid_q_i;
    assign desync_evt = ((state_reg == ST_WARMUP) || (state_reg == ST_RUN)) &&
                        (filt_valid_i_i != filt_valid_q_i);
    assign drop_evt   = demod_valid_reg & ~cordic_ready_i;

    always_comb begin
        state_next       = state_reg;
        sample_en_next   = 1'b0;
        zero_sample_next = 1'b0;
        demod_valid_next = 1'b0;
        flush_inc        = 1'b0;
        warm_inc         = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (enable_i && !enable_prev_reg) state_next = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (gap_term) begin
                    sample_en_next   = 1'b1;
                    zero_sample_next = 1'b1;
                    flush_inc        = 1'b1;
                    if (flush_cnt == FL_W'(NTAPS - 1)) state_next = ST_WARMUP;
                end
            end
            ST_WARMUP: begin
                sample_en_next = adc_rdy_i & ~desync_evt;
                if (desync_evt) begin
                    state_next = ST_FLUSH;
                end else if (pair) begin
                    warm_inc = 1'b1;
                    if (warm_cnt == WU_W'(WARMUP - 1)) state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                sample_en_next = adc_rdy_i & ~desync_evt;
                if (desync_evt) state_next = ST_FLUSH;
                else            demod_valid_next = pair;
            end
            default: state_next = ST_IDLE;
        endcase
        // Dropping enable overrides everything, including a strobe arriving this cycle.
        if (!enable_i) begin
            state_next       = ST_IDLE;
            sample_en_next   = 1'b0;
            zero_sample_next = 1'b0;
            demod_valid_next = 1'b0;
            flush_inc        = 1'b0;
            warm_inc         = 1'b0;
        end
    end

    assign cnt_clr      = (state_next != state_reg);
    assign nco_clr_next = (state_next == ST_FLUSH) && (state_reg != ST_FLUSH);

    always_comb begin
        gap_next = '0;
        if ((state_reg == ST_FLUSH) && (state_next == ST_FLUSH) && !gap_term) begin
            gap_next = gap_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            state_reg       <= ST_IDLE;
            enable_prev_reg <= 1'b0;
            gap_reg         <= '0;
            sample_en_reg   <= 1'b0;
            zero_sample_reg <= 1'b0;
            nco_clr_reg     <= 1'b0;
            demod_valid_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            enable_prev_reg <= enable_i;
            gap_reg         <= gap_next;
            sample_en_reg   <= sample_en_next;
            zero_sample_reg <= zero_sample_next;
            nco_clr_reg     <= nco_clr_next;
            demod_valid_reg <= demod_valid_next;
        end
    end

    iq_ctrl_sat_cnt #(.W(FL_W), .MAX(NTAPS)) u_flush_cnt (
        .clk  (clk),
        .srst (resetn),
        .clr  (cnt_clr),
        .inc  (flush_inc & ~cnt_clr),
        .cnt  (flush_cnt)
    );

    iq_ctrl_sat_cnt #(.W(WU_W), .MAX(WARMUP)) u_warm_cnt (
        .clk  (clk),
        .srst (resetn),
        .clr  (cnt_clr),
        .inc  (warm_inc & ~cnt_clr),
        .cnt  (warm_cnt)
    );

    iq_ctrl_sat_cnt #(.W(CNT_W), .MAX((1 << CNT_W) - 1)) u_drop_cnt (
        .clk  (clk),
        .srst (resetn),
        .clr  (clr_err_i),
        .inc  (drop_evt),
        .cnt  (drop_cnt_o)
    );

    // Sticky error flags: bit 0 overrun, bit 1 desync; a set beats a clear.
    assign flag_set = {desync_evt, drop_evt};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_flag
            logic flag_reg;
            always_ff @(posedge clk) begin
                if (resetn)             flag_reg <= 1'b0;
                else if (flag_set[gi])  flag_reg <= 1'b1;
                else if (clr_err_i)     flag_reg <= 1'b0;
            end
            assign flags[gi] = flag_reg;
        end
    endgenerate

    assign sample_en_o      = sample_en_reg;
    assign zero_sample_o    = zero_sample_reg;
    assign nco_clr_o        = nco_clr_reg;
    assign demod_iq_valid_o = demod_valid_reg;
    assign state_o          = state_reg;
    assign overrun_o        = flags[0];
    assign desync_o         = flags[1];

endmodule

// File: tb/tb_iq_demod_ctrl.sv
// Scoreboard bench for iq_demod_ctrl: expected strobe cycles are queued as
// stimulus is driven and matched against the outputs every cycle.
module tb_iq_demod_ctrl;

    localparam int NTAPS  = 20;
    localparam int WARMUP = 20;
    localparam int GAP    = 4;
    localparam int CNT_W  = 8;

    logic             clk = 1'b0;
    logic             resetn, enable_i, clr_err_i, adc_rdy_i;
    logic             filt_valid_i_i, filt_valid_q_i, cordic_ready_i;
    logic             sample_en_o, zero_sample_o, nco_clr_o, demod_iq_valid_o;
    logic [1:0]       state_o;
    logic             overrun_o, desync_o;
    logic [CNT_W-1:0] drop_cnt_o;

    int cyc = 0;
    int n_cmp = 0;
    int n_err = 0;

    int sb_smp[$];
    int sb_zero[$];
    int sb_nco[$];
    int sb_dv[$];

    always #5 clk = ~clk;

    iq_demod_ctrl #(.NTAPS(NTAPS), .WARMUP(WARMUP), .FLUSH_GAP(GAP), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .resetn           (resetn),
        .enable_i         (enable_i),
        .clr_err_i        (clr_err_i),
        .adc_rdy_i        (adc_rdy_i),
        .filt_valid_i_i   (filt_valid_i_i),
        .filt_valid_q_i   (filt_valid_q_i),
        .cordic_ready_i   (cordic_ready_i),
        .sample_en_o      (sample_en_o),
        .zero_sample_o    (zero_sample_o),
        .nco_clr_o        (nco_clr_o),
        .demod_iq_valid_o (demod_iq_valid_o),
        .state_o          (state_o),
        .overrun_o        (overrun_o),
        .desync_o         (desync_o),
        .drop_cnt_o       (drop_cnt_o)
    );

    task automatic check_val(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Per-cycle scoreboard match; all expected cycles are pushed in ascending order.
    always @(negedge clk) begin
        int exp_s, exp_n, exp_d, exp_z;
        exp_s = (sb_smp.size() > 0 && sb_smp[0] == cyc) ? 1 : 0;
        exp_n = (sb_nco.size() > 0 && sb_nco[0] == cyc) ? 1 : 0;
        exp_d = (sb_dv.size()  > 0 && sb_dv[0]  == cyc) ? 1 : 0;
        exp_z = 0;
        if (exp_s == 1) begin
            void'(sb_smp.pop_front());
            exp_z = sb_zero.pop_front();
        end
        if (exp_n == 1) void'(sb_nco.pop_front());
        if (exp_d == 1) void'(sb_dv.pop_front());
        check_val("sample_en", int'(sample_en_o), exp_s);
        check_val("zero_sample", int'(zero_sample_o), exp_z);
        check_val("nco_clr", int'(nco_clr_o), exp_n);
        check_val("demod_iq_valid", int'(demod_iq_valid_o), exp_d);
    end

    task automatic flush_run(input int e, input int abort_at);
        for (int i = 1; i <= NTAPS; i++) begin
            if (abort_at < 0 || GAP * i <= abort_at) begin
                sb_smp.push_back(e + GAP * i);
                sb_zero.push_back(1);
            end
        end
        adc_rdy_i = 1'b1;
        if (abort_at < 0) begin
            while (cyc < e + NTAPS * GAP - 1) tick();
            check_val("state_flush_last", int'(state_o), 1);
            tick();
            adc_rdy_i = 1'b0;
            check_val("state_warmup_entry", int'(state_o), 2);
        end else begin
            while (cyc < e + abort_at) tick();
            enable_i = 1'b0;
            tick();
            adc_rdy_i = 1'b0;
            check_val("state_flush_abort", int'(state_o), 0);
        end
    endtask

    task automatic start_session(input int abort_at);
        enable_i = 1'b1;
        sb_nco.push_back(cyc + 1);
        tick();
        check_val("state_flush_start", int'(state_o), 1);
        flush_run(cyc, abort_at);
    endtask

    task automatic warmup_pairs(input int npairs);
        for (int k = 1; k <= npairs; k++) begin
            adc_rdy_i = 1'b1;
            filt_valid_i_i = 1'b1;
            filt_valid_q_i = 1'b1;
            sb_smp.push_back(cyc + 1);
            sb_zero.push_back(0);
            if (k > WARMUP) sb_dv.push_back(cyc + 1);
            tick();
            adc_rdy_i = 1'b0;
            filt_valid_i_i = 1'b0;
            filt_valid_q_i = 1'b0;
            tick();
        end
    endtask

    initial begin
        resetn = 1'b1;
        enable_i = 1'b0;
        clr_err_i = 1'b0;
        adc_rdy_i = 1'b0;
        filt_valid_i_i = 1'b0;
        filt_valid_q_i = 1'b0;
        cordic_ready_i = 1'b1;
        repeat (3) tick();
        check_val("rst_state", int'(state_o), 0);
        check_val("rst_overrun", int'(overrun_o), 0);
        check_val("rst_desync", int'(desync_o), 0);
        check_val("rst_drop", int'(drop_cnt_o), 0);
        resetn = 1'b0;
        tick();

        // Start-up: phase clear, full zero flush with ADC strobes ignored, warm-up.
        start_session(-1);
        warmup_pairs(25);
        check_val("state_run", int'(state_o), 3);

        // Back-pressure: every forwarded sample is dropped.
        cordic_ready_i = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (k == 1)   check_val("overrun_before_drop", int'(overrun_o), 0);
            if (k == 2)   check_val("overrun_first_drop", int'(overrun_o), 1);
            if (k == 12)  check_val("drop_cnt_11", int'(drop_cnt_o), 11);
            if (k == 255) check_val("drop_cnt_254", int'(drop_cnt_o), 254);
            filt_valid_i_i = 1'b1;
            filt_valid_q_i = 1'b1;
            sb_dv.push_back(cyc + 1);
            tick();
        end
        filt_valid_i_i = 1'b0;
        filt_valid_q_i = 1'b0;
        repeat (2) tick();
        check_val("overrun_sticky", int'(overrun_o), 1);
        check_val("drop_cnt_sat", int'(drop_cnt_o), 255);
        clr_err_i = 1'b1;
        tick();
        clr_err_i = 1'b0;
        check_val("overrun_cleared", int'(overrun_o), 0);
        check_val("drop_cnt_cleared", int'(drop_cnt_o), 0);
        filt_valid_i_i = 1'b1;
        filt_valid_q_i = 1'b1;
        sb_dv.push_back(cyc + 1);
        tick();
        filt_valid_i_i = 1'b0;
        filt_valid_q_i = 1'b0;
        clr_err_i = 1'b1;
        tick();
        clr_err_i = 1'b0;
        check_val("overrun_set_wins", int'(overrun_o), 1);
        cordic_ready_i = 1'b1;
        check_val("desync_before", int'(desync_o), 0);

        // Desync in RUN: restart with a full flush.
        filt_valid_i_i = 1'b1;
        sb_nco.push_back(cyc + 1);
        tick();
        filt_valid_i_i = 1'b0;
        check_val("desync_state", int'(state_o), 1);
        check_val("desync_flag", int'(desync_o), 1);
        flush_run(cyc, -1);

        // Enable low in WARMUP, then mid-FLUSH, then mid-RUN.
        enable_i = 1'b0;
        tick();
        check_val("disable_warmup_state", int'(state_o), 0);
        check_val("disable_desync_kept", int'(desync_o), 1);
        start_session(42);
        check_val("abort_desync_kept", int'(desync_o), 1);
        start_session(-1);
        warmup_pairs(WARMUP);
        check_val("state_run_again", int'(state_o), 3);
        enable_i = 1'b0;
        adc_rdy_i = 1'b1;
        filt_valid_i_i = 1'b1;
        filt_valid_q_i = 1'b1;
        tick();
        adc_rdy_i = 1'b0;
        filt_valid_i_i = 1'b0;
        filt_valid_q_i = 1'b0;
        check_val("disable_run_state", int'(state_o), 0);
        check_val("disable_overrun_kept", int'(overrun_o), 1);
        check_val("disable_desync_kept2", int'(desync_o), 1);
        tick();

        // Reset mid-RUN with strobes active.
        start_session(-1);
        warmup_pairs(WARMUP);
        for (int k = 0; k < 5; k++) begin
            adc_rdy_i = 1'b1;
            filt_valid_i_i = 1'b1;
            filt_valid_q_i = 1'b1;
            sb_smp.push_back(cyc + 1);
            sb_zero.push_back(0);
            sb_dv.push_back(cyc + 1);
            tick();
        end
        resetn = 1'b1;
        tick();
        resetn = 1'b0;
        enable_i = 1'b0;
        adc_rdy_i = 1'b0;
        filt_valid_i_i = 1'b0;
        filt_valid_q_i = 1'b0;
        check_val("midrst_state", int'(state_o), 0);
        check_val("midrst_sample_en", int'(sample_en_o), 0);
        check_val("midrst_demod_valid", int'(demod_iq_valid_o), 0);
        check_val("midrst_overrun", int'(overrun_o), 0);
        check_val("midrst_desync", int'(desync_o), 0);
        check_val("midrst_drop", int'(drop_cnt_o), 0);
        repeat (3) tick();

        check_val("sb_sample_left", sb_smp.size(), 0);
        check_val("sb_nco_left", sb_nco.size(), 0);
        check_val("sb_valid_left", sb_dv.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
